// File: rtl/npu_lb_pkg.sv
// Shared definitions for the line-buffer path: image geometry defaults and feeder FSM states.
package npu_lb_pkg;

   localparam int unsigned LbBitDepth = 8;
   localparam int unsigned LbRows     = 28;
   localparam int unsigned LbCols     = 28;

   typedef enum logic [1:0] {
      StIdle,
      StRd,
      StDrain
   } lb_state_e;

endpackage

// File: rtl/lb_addr_gen.sv
// Read address generator: phase/column/band counters with an incrementally kept address.
module lb_addr_gen
   import npu_lb_pkg::*;
#(
   parameter int unsigned ROWS   = LbRows,
   parameter int unsigned COLS   = LbCols,
   parameter int unsigned ADDR_W = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     advance,
   output logic [1:0]               phase,
   output logic [$clog2(ROWS)-1:0]  band,
   output logic [ADDR_W-1:0]        addr,
   output logic                     last_col,
   output logic                     last_band
);

   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned BW = $clog2(ROWS);
   localparam logic [ADDR_W-1:0] ColStep = ADDR_W'(COLS);

   logic [1:0]        p_q;
   logic [CW-1:0]     c_q;
   logic [BW-1:0]     b_q;
   // base_q = b*COLS + c; it simply counts columns, since the last column of band b
   // is followed by column 0 of band b+1 at the next linear address.
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] off_q;

   // Counter update: one step per issued read, cleared while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q    <= 2'd0;
         c_q    <= '0;
         b_q    <= '0;
         base_q <= '0;
         off_q  <= '0;
      end else if (clear) begin
         p_q    <= 2'd0;
         c_q    <= '0;
         b_q    <= '0;
         base_q <= '0;
         off_q  <= '0;
      end else if (advance) begin
         if (p_q != 2'd2) begin
            p_q   <= p_q + 2'd1;
            off_q <= off_q + ColStep;
         end else begin
            p_q    <= 2'd0;
            off_q  <= '0;
            base_q <= base_q + ADDR_W'(1);
            if (last_col) begin
               c_q <= '0;
               b_q <= b_q + BW'(1);
            end else begin
               c_q <= c_q + CW'(1);
            end
         end
      end
   end

   assign phase     = p_q;
   assign band      = b_q;
   assign addr      = base_q + off_q;
   assign last_col  = (c_q == CW'(COLS - 1));
   assign last_band = (b_q == BW'(ROWS - 3));

endmodule

// File: rtl/linebuffer_feeder.sv
// Sweeps an image in SRAM band by band and pushes aligned pixel triplets into the line buffer.
module linebuffer_feeder
   import npu_lb_pkg::*;
#(
   parameter int unsigned BIT_DEPTH = LbBitDepth,
   parameter int unsigned ROWS      = LbRows,
   parameter int unsigned COLS      = LbCols,
   parameter int unsigned ADDR_W    = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     hold,
   output logic                     busy,
   output logic                     done,
   output logic                     band_done,
   output logic [$clog2(ROWS)-1:0]  band_idx,
   output logic                     mem_rd_en,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic [BIT_DEPTH-1:0]     mem_rd_data,
   output logic                     lb_shift,
   output logic [BIT_DEPTH-1:0]     lb_data_r1,
   output logic [BIT_DEPTH-1:0]     lb_data_r2,
   output logic [BIT_DEPTH-1:0]     lb_data_r3
);

   lb_state_e state_q, state_d;

   logic       issue, last_issue, complete, emit;
   logic [1:0] phase;
   logic       last_col, last_band;

   // Tags of the read issued last cycle, aligned with mem_rd_data.
   logic       cap_vld_q, cap_bd_q, cap_dn_q;
   logic [1:0] cap_ph_q;

   logic [BIT_DEPTH-1:0] stg1_q, stg2_q, stg3_q;
   logic                 pend_q, pend_bd_q, pend_dn_q;
   logic                 busy_q, done_q, bd_q, shift_q;
   logic [BIT_DEPTH-1:0] r1_q, r2_q, r3_q;

   assign issue      = (state_q == StRd) && !hold;
   assign last_issue = issue && (phase == 2'd2) && last_col && last_band;
   assign complete   = cap_vld_q && (cap_ph_q == 2'd2);
   // A triplet leaves either straight from the returning read or from the pending slot.
   assign emit       = !hold && (complete || pend_q);

   lb_addr_gen #(
      .ROWS   (ROWS),
      .COLS   (COLS),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (state_q == StIdle),
      .advance   (issue),
      .phase     (phase),
      .band      (band_idx),
      .addr      (mem_addr),
      .last_col  (last_col),
      .last_band (last_band)
   );

   // Next-state: run until the last read is issued, then wait for the final push.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start)      state_d = StRd;
         StRd:    if (last_issue) state_d = StDrain;
         StDrain: if (done_q)     state_d = StIdle;
         default:                 state_d = StIdle;
      endcase
   end

   // State register and busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != StIdle);
      end
   end

   // Capture returning pixels into staging, parking a completed triplet while held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_vld_q <= 1'b0;
         cap_ph_q  <= 2'd0;
         cap_bd_q  <= 1'b0;
         cap_dn_q  <= 1'b0;
         stg1_q    <= '0;
         stg2_q    <= '0;
         stg3_q    <= '0;
         pend_q    <= 1'b0;
         pend_bd_q <= 1'b0;
         pend_dn_q <= 1'b0;
      end else begin
         cap_vld_q <= issue;
         cap_ph_q  <= phase;
         cap_bd_q  <= issue && (phase == 2'd2) && last_col;
         cap_dn_q  <= last_issue;
         if (cap_vld_q && (cap_ph_q == 2'd0)) stg1_q <= mem_rd_data;
         if (cap_vld_q && (cap_ph_q == 2'd1)) stg2_q <= mem_rd_data;
         if (complete) begin
            stg3_q    <= mem_rd_data;
            pend_bd_q <= cap_bd_q;
            pend_dn_q <= cap_dn_q;
         end
         pend_q <= (complete || pend_q) && hold;
      end
   end

   // Registered line-buffer write: data, shift and band/sweep markers leave together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= 1'b0;
         bd_q    <= 1'b0;
         done_q  <= 1'b0;
         r1_q    <= '0;
         r2_q    <= '0;
         r3_q    <= '0;
      end else begin
         shift_q <= emit;
         bd_q    <= emit && (complete ? cap_bd_q : pend_bd_q);
         done_q  <= emit && (complete ? cap_dn_q : pend_dn_q);
         if (emit) begin
            r1_q <= stg1_q;
            r2_q <= stg2_q;
            r3_q <= complete ? mem_rd_data : stg3_q;
         end
      end
   end

   assign mem_rd_en  = issue;
   assign busy       = busy_q;
   assign done       = done_q;
   assign band_done  = bd_q;
   assign lb_shift   = shift_q;
   assign lb_data_r1 = r1_q;
   assign lb_data_r2 = r2_q;
   assign lb_data_r3 = r3_q;

endmodule
